// File: rtl/freelist_pkg.sv
// Shared types and sizing helpers for the multi-pool buffer-ID freelist.
package freelist_pkg;

    // Controller phases: fill every pool once, then serve traffic.
    typedef enum logic {
        StInit,
        StRun
    } fsm_t;

    // Global ID width for num_pools pools of depth IDs each.
    function automatic int unsigned id_w(input int unsigned num_pools,
                                         input int unsigned depth);
        return $clog2(num_pools * depth);
    endfunction

    // Occupancy counter width; must represent a full pool (depth itself).
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // Owning pool of a global ID; depth is a power of two so this is a shift.
    function automatic int unsigned pool_select(input logic [31:0] id,
                                                input int unsigned depth);
        return id / depth;
    endfunction

endpackage

// File: rtl/freelist_pool.sv
// One pool: LUTRAM FIFO of local indices with a registered show-ahead head,
// an occupancy counter and a registered low-watermark flag.
module freelist_pool
    import freelist_pkg::*;
#(
    parameter int unsigned POOL_DEPTH = 256,
    parameter int unsigned LOW_WATER  = 8
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          push_i,
    input  logic [$clog2(POOL_DEPTH)-1:0] push_idx_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [$clog2(POOL_DEPTH)-1:0] head_idx_o,
    output logic [cnt_w(POOL_DEPTH)-1:0]  count_o,
    output logic                          low_o
);
    localparam int unsigned IdxW = $clog2(POOL_DEPTH);
    localparam int unsigned CntW = cnt_w(POOL_DEPTH);

    logic [IdxW-1:0] mem_q [POOL_DEPTH];
    logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0] head_q, head_d;
    logic            head_vld_q, head_vld_d;
    logic [CntW-1:0] count_q, count_d;
    logic            low_q, low_d;
    logic            pop;
    logic            head_load;

    // The head is only offered to clients once the pool is enabled.
    assign valid_o    = en_i & head_vld_q;
    assign pop        = valid_o & ready_i;
    assign head_idx_o = head_q;
    assign count_o    = count_q;
    assign low_o      = low_q;

    // Next-state: write pointer, head refill from RAM, occupancy and watermark.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        // count_q includes the head entry; anything beyond it is in the RAM.
        head_load  = (count_q > CntW'(head_vld_q)) && (!head_vld_q || pop);
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + IdxW'(1);
        end
        if (head_load) begin
            head_d     = mem_q[rd_ptr_q];
            head_vld_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + IdxW'(1);
        end else if (pop) begin
            head_vld_d = 1'b0;
        end
        count_d = count_q + CntW'(push_i) - CntW'(pop);
        low_d   = 32'(count_d) < LOW_WATER;
    end

    // LUTRAM storage: no reset, pointers alone define the contents.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_idx_i;
        end
    end

    // Pool state registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            count_q    <= '0;
            low_q      <= (LOW_WATER != 0);
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            count_q    <= count_d;
            low_q      <= low_d;
        end
    end

endmodule

// File: rtl/multi_pool_freelist.sv
// Multi-pool buffer-ID freelist: init FSM, in-list bitmap, free routing,
// error reporting, and NUM_POOLS pool FIFOs.
module multi_pool_freelist
    import freelist_pkg::*;
#(
    parameter int unsigned NUM_POOLS  = 4,
    parameter int unsigned POOL_DEPTH = 256,
    parameter int unsigned LOW_WATER  = 8,
    // Derived from the two above; leave at its default.
    parameter int unsigned ID_W       = id_w(NUM_POOLS, POOL_DEPTH)
) (
    input  logic                                     clock,
    input  logic                                     rst,
    input  logic                                     free_valid,
    input  logic [ID_W-1:0]                          free_id,
    output logic [NUM_POOLS-1:0]                     alloc_valid,
    output logic [NUM_POOLS*ID_W-1:0]                alloc_id,
    input  logic [NUM_POOLS-1:0]                     alloc_ready,
    output logic [NUM_POOLS*cnt_w(POOL_DEPTH)-1:0]   free_count,
    output logic [NUM_POOLS-1:0]                     pool_low,
    output logic                                     init_done,
    output logic                                     err_double_free,
    output logic                                     err_early_free,
    output logic [ID_W-1:0]                          err_id
);
    localparam int unsigned IdxW   = $clog2(POOL_DEPTH);
    localparam int unsigned CntW   = cnt_w(POOL_DEPTH);
    localparam int unsigned NumIds = NUM_POOLS * POOL_DEPTH;

    fsm_t              fsm_q, fsm_d;
    logic [IdxW-1:0]   init_idx_q, init_idx_d;
    logic              init_done_q, init_done_d;
    logic [NumIds-1:0] bitmap_q, bitmap_d;
    logic              fpush_vld_q, fpush_vld_d;
    logic [ID_W-1:0]   fpush_id_q, fpush_id_d;
    logic              err_dbl_q, err_dbl_d;
    logic              err_early_q, err_early_d;
    logic [ID_W-1:0]   err_id_q, err_id_d;

    logic [NUM_POOLS-1:0] pool_push;
    logic [IdxW-1:0]      pool_push_idx [NUM_POOLS];
    logic [NUM_POOLS-1:0] pool_pop;
    logic [ID_W-1:0]      alloc_gid [NUM_POOLS];
    logic                 free_in_range;

    assign init_done       = init_done_q;
    assign err_double_free = err_dbl_q;
    assign err_early_free  = err_early_q;
    assign err_id          = err_id_q;

    // IDs beyond the last pool (non power-of-two pool counts) are ignored.
    assign free_in_range = 32'(free_id) < NumIds;

    // Pool write routing: all pools during init, else the registered free.
    always_comb begin
        for (int unsigned p = 0; p < NUM_POOLS; p++) begin
            pool_push[p]     = 1'b0;
            pool_push_idx[p] = init_idx_q;
            if (fsm_q == StInit) begin
                pool_push[p] = 1'b1;
            end else begin
                pool_push[p] = fpush_vld_q
                               && (pool_select(32'(fpush_id_q), POOL_DEPTH) == p);
                pool_push_idx[p] = fpush_id_q[IdxW-1:0];
            end
        end
    end

    // FSM, bitmap maintenance, free acceptance and error pulses.
    always_comb begin
        fsm_d       = fsm_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        bitmap_d    = bitmap_q;
        fpush_vld_d = 1'b0;
        fpush_id_d  = fpush_id_q;
        err_dbl_d   = 1'b0;
        err_early_d = 1'b0;
        err_id_d    = err_id_q;

        unique case (fsm_q)
            StInit: begin
                for (int unsigned p = 0; p < NUM_POOLS; p++) begin
                    bitmap_d[ID_W'(p * POOL_DEPTH) + ID_W'(init_idx_q)] = 1'b1;
                end
                init_idx_d = init_idx_q + IdxW'(1);
                if (init_idx_q == IdxW'(POOL_DEPTH - 1)) begin
                    fsm_d       = StRun;
                    init_done_d = 1'b1;
                end
            end
            StRun: begin
            end
        endcase

        for (int unsigned p = 0; p < NUM_POOLS; p++) begin
            if (pool_pop[p]) begin
                bitmap_d[alloc_gid[p]] = 1'b0;
            end
        end

        // Bitmap is read pre-allocation, so freeing the ID being popped this
        // cycle is reported as a double free.
        if (free_valid) begin
            if (!init_done_q) begin
                err_early_d = 1'b1;
                err_id_d    = free_id;
            end else if (free_in_range) begin
                if (bitmap_q[free_id]) begin
                    err_dbl_d = 1'b1;
                    err_id_d  = free_id;
                end else begin
                    bitmap_d[free_id] = 1'b1;
                    fpush_vld_d       = 1'b1;
                    fpush_id_d        = free_id;
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fsm_q       <= StInit;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            bitmap_q    <= '0;
            fpush_vld_q <= 1'b0;
            fpush_id_q  <= '0;
            err_dbl_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_id_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            bitmap_q    <= bitmap_d;
            fpush_vld_q <= fpush_vld_d;
            fpush_id_q  <= fpush_id_d;
            err_dbl_q   <= err_dbl_d;
            err_early_q <= err_early_d;
            err_id_q    <= err_id_d;
        end
    end

    for (genvar p = 0; p < NUM_POOLS; p++) begin : g_pool
        logic [IdxW-1:0] head_idx;

        freelist_pool #(
            .POOL_DEPTH (POOL_DEPTH),
            .LOW_WATER  (LOW_WATER)
        ) u_pool (
            .clock      (clock),
            .rst        (rst),
            .en_i       (init_done_q),
            .push_i     (pool_push[p]),
            .push_idx_i (pool_push_idx[p]),
            .ready_i    (alloc_ready[p]),
            .valid_o    (alloc_valid[p]),
            .head_idx_o (head_idx),
            .count_o    (free_count[p*CntW +: CntW]),
            .low_o      (pool_low[p])
        );

        assign alloc_gid[p]             = ID_W'(p * POOL_DEPTH) + ID_W'(head_idx);
        assign alloc_id[p*ID_W +: ID_W] = alloc_gid[p];
        assign pool_pop[p]              = alloc_valid[p] & alloc_ready[p];
    end

endmodule

// File: tb/tb_multi_pool_freelist.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_multi_pool_freelist;
    localparam int NP  = 4;
    localparam int PD  = 256;
    localparam int LW  = 8;
    localparam int IDW = 10;
    localparam int CW  = 9;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              free_valid = 1'b0;
    logic [IDW-1:0]    free_id = '0;
    logic [NP-1:0]     alloc_valid;
    logic [NP*IDW-1:0] alloc_id;
    logic [NP-1:0]     alloc_ready = '0;
    logic [NP*CW-1:0]  free_count;
    logic [NP-1:0]     pool_low;
    logic              init_done;
    logic              err_double_free;
    logic              err_early_free;
    logic [IDW-1:0]    err_id;

    int errors = 0;
    int checks = 0;

    multi_pool_freelist #(
        .NUM_POOLS  (NP),
        .POOL_DEPTH (PD),
        .LOW_WATER  (LW)
    ) dut (
        .clock           (clock),
        .rst             (rst),
        .free_valid      (free_valid),
        .free_id         (free_id),
        .alloc_valid     (alloc_valid),
        .alloc_id        (alloc_id),
        .alloc_ready     (alloc_ready),
        .free_count      (free_count),
        .pool_low        (pool_low),
        .init_done       (init_done),
        .err_double_free (err_double_free),
        .err_early_free  (err_early_free),
        .err_id          (err_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int cnt(input int p);
        return int'(free_count[p*CW +: CW]);
    endfunction
    function automatic int aid(input int p);
        return int'(alloc_id[p*IDW +: IDW]);
    endfunction
    function automatic int av(input int p);
        return int'(alloc_valid[p]);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int id;
        int t;   // edge at which the ID entered the pool
    } ent_t;

    ent_t mq [NP][$];
    bit   inlist [NP*PD];
    int   edge_n, init_cnt, m_err_id, pend_id;
    bit   m_init_done, m_err_dbl, m_err_early, pend_vld;

    // An ID becomes the visible head one edge after it entered its pool.
    function automatic bit m_valid(input int p);
        return m_init_done && mq[p].size() > 0 && mq[p][0].t < edge_n;
    endfunction

    task automatic m_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        for (int i = 0; i < NP*PD; i++) inlist[i] = 1'b0;
        edge_n = 0; init_cnt = 0; m_init_done = 0;
        m_err_dbl = 0; m_err_early = 0; m_err_id = 0;
        pend_vld = 0; pend_id = 0;
    endtask

    task automatic m_step();
        int   e, fid;
        bit   acc;
        bit   pop [NP];
        ent_t en;
        e = edge_n + 1;
        for (int p = 0; p < NP; p++) pop[p] = m_valid(p) && alloc_ready[p];
        m_err_dbl = 0; m_err_early = 0; acc = 0;
        fid = int'(free_id);
        if (free_valid) begin
            if (!m_init_done) begin m_err_early = 1; m_err_id = fid; end
            else if (inlist[fid]) begin m_err_dbl = 1; m_err_id = fid; end
            else acc = 1;
        end
        if (pend_vld) begin
            en.id = pend_id; en.t = e;
            mq[pend_id / PD].push_back(en);
        end
        for (int p = 0; p < NP; p++) begin
            if (pop[p]) begin
                inlist[mq[p][0].id] = 1'b0;
                void'(mq[p].pop_front());
            end
        end
        pend_vld = acc; pend_id = fid;
        if (acc) inlist[fid] = 1'b1;
        if (!m_init_done) begin
            for (int p = 0; p < NP; p++) begin
                en.id = p*PD + init_cnt; en.t = e;
                mq[p].push_back(en);
                inlist[en.id] = 1'b1;
            end
            init_cnt++;
            if (init_cnt == PD) m_init_done = 1;
        end
        edge_n = e;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clock or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            chk("init_done", int'(init_done), int'(m_init_done));
            chk("err_double_free", int'(err_double_free), int'(m_err_dbl));
            chk("err_early_free", int'(err_early_free), int'(m_err_early));
            chk("err_id", int'(err_id), m_err_id);
            for (int p = 0; p < NP; p++) begin
                chk($sformatf("alloc_valid[%0d]", p), av(p), int'(m_valid(p)));
                if (m_valid(p)) chk($sformatf("alloc_id[%0d]", p), aid(p), mq[p][0].id);
                chk($sformatf("free_count[%0d]", p), cnt(p), mq[p].size());
                chk($sformatf("pool_low[%0d]", p), int'(pool_low[p]),
                    int'(mq[p].size() < LW));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_init(input string name, input int exp);
        int n;
        n = 0;
        while (!init_done && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(name, n, exp);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_alloc_valid", int'(alloc_valid), 0);
        chk("rst_free_count", int'(free_count), 0);
        chk("rst_pool_low", int'(pool_low), 15);
        chk("rst_err_id", int'(err_id), 0);
        rst = 1'b0;
        wait_init("init_latency", 256);

        // Pool 2 back-to-back allocation.
        chk("p2_count_full", cnt(2), 256);
        alloc_ready = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            chk("p2_valid", av(2), 1);
            chk("p2_id", aid(2), 512 + i);
            @(negedge clock);
        end
        alloc_ready = '0;
        chk("p2_count", cnt(2), 253);

        // Drain pool 0, with extra ready cycles while empty.
        alloc_ready = 4'b0001;
        repeat (260) @(negedge clock);
        alloc_ready = '0;
        chk("p0_empty_valid", av(0), 0);
        chk("p0_empty_count", cnt(0), 0);
        chk("p0_empty_low", int'(pool_low[0]), 1);
        free_valid = 1'b1; free_id = 10'd17;
        @(negedge clock);
        free_valid = 1'b0;
        chk("free_k_count", cnt(0), 0);
        chk("free_k_valid", av(0), 0);
        @(negedge clock);
        chk("free_k1_count", cnt(0), 1);
        chk("free_k1_valid", av(0), 0);
        @(negedge clock);
        chk("free_k2_valid", av(0), 1);
        chk("free_k2_id", aid(0), 17);

        // Return every other pool-0 ID, then free 5 a second time.
        for (int i = 0; i < PD; i++) begin
            if (i != 17) begin
                free_valid = 1'b1; free_id = IDW'(i);
                @(negedge clock);
            end
        end
        free_id = 10'd5;
        @(negedge clock);
        free_valid = 1'b0;
        chk("dbl5_pulse", int'(err_double_free), 1);
        chk("dbl5_id", int'(err_id), 5);
        @(negedge clock);
        chk("dbl5_one_cycle", int'(err_double_free), 0);
        chk("dbl5_id_held", int'(err_id), 5);
        chk("dbl5_count", cnt(0), 256);
        free_valid = 1'b1; free_id = 10'd300;
        @(negedge clock);
        free_valid = 1'b0;
        chk("dbl300_pulse", int'(err_double_free), 1);
        chk("dbl300_id", int'(err_id), 300);
        chk("p1_count_full", cnt(1), 256);

        // Pool 1 down to 100, then simultaneous allocate and free.
        alloc_ready = 4'b0010;
        repeat (156) @(negedge clock);
        alloc_ready = '0;
        chk("p1_count_100", cnt(1), 100);
        chk("p1_head_412", aid(1), 412);
        alloc_ready = 4'b0010; free_valid = 1'b1; free_id = 10'd260;
        @(negedge clock);
        alloc_ready = '0; free_valid = 1'b0;
        chk("same_no_err", int'(err_double_free), 0);
        @(negedge clock);
        chk("same_count", cnt(1), 100);
        chk("p1_head_413", aid(1), 413);
        alloc_ready = 4'b0010; free_valid = 1'b1; free_id = 10'd413;
        @(negedge clock);
        alloc_ready = '0; free_valid = 1'b0;
        chk("self_free_err", int'(err_double_free), 1);
        chk("self_free_id", int'(err_id), 413);
        chk("self_free_count", cnt(1), 99);

        // Free during init after a reset.
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        repeat (10) @(negedge clock);
        free_valid = 1'b1; free_id = 10'd3;
        @(negedge clock);
        free_valid = 1'b0;
        chk("early_pulse", int'(err_early_free), 1);
        chk("early_not_dbl", int'(err_double_free), 0);
        chk("early_id", int'(err_id), 3);
        wait_init("reinit1_latency", 245);
        chk("reinit1_count", cnt(0), 256);
        alloc_ready = 4'b0001;
        for (int i = 0; i < PD; i++) begin
            chk("reinit1_p0_id", aid(0), i);
            @(negedge clock);
        end
        alloc_ready = '0;

        // All pools in one cycle, then 99 more from pool 3, then async reset.
        alloc_ready = 4'b1111;
        @(negedge clock);
        alloc_ready = '0;
        chk("all_p1", cnt(1), 255);
        chk("all_p2", cnt(2), 255);
        chk("all_p3", cnt(3), 255);
        alloc_ready = 4'b1000;
        repeat (99) @(negedge clock);
        alloc_ready = '0;
        chk("p3_count_156", cnt(3), 156);
        chk("p3_head_868", aid(3), 868);
        @(posedge clock);
        #2 rst = 1'b1;
        #1;
        chk("async_alloc_valid", int'(alloc_valid), 0);
        chk("async_init_done", int'(init_done), 0);
        @(negedge clock);
        rst = 1'b0;
        wait_init("reinit2_latency", 256);
        chk("reinit2_count", cnt(3), 256);
        alloc_ready = 4'b1000;
        for (int i = 0; i < PD; i++) begin
            chk("reinit2_p3_id", aid(3), 768 + i);
            @(negedge clock);
        end
        alloc_ready = '0;
        @(negedge clock);
        chk("p3_drained", av(3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_pool_freelist.md
Name: multi_pool_freelist

Overview:
- Single-clock, multi-pool buffer-ID freelist. Successor to the single-pool freelist used by the switch buffer managers.
- Manages NUM_POOLS independent pools of POOL_DEPTH IDs each. Pool p owns global IDs [p*POOL_DEPTH, (p+1)*POOL_DEPTH).
- Self-initialises all pools in parallel after reset. Provides per-pool allocate handshakes and one shared free port.
- Adds features the previous generation lacks: double-free detection via an in-list bitmap, per-pool occupancy counts, low-watermark flags, and error reporting.

Parameters:
- NUM_POOLS, 4, number of independent pools (>=1).
- POOL_DEPTH, 256, IDs per pool; power of two, >=4.
- LOW_WATER, 8, a pool's low flag is asserted while its free count < LOW_WATER.
- ID_W, $clog2(NUM_POOLS*POOL_DEPTH), global ID width (derived; do not override).

Ports:
- clock  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- free_valid  in  1  return one ID this cycle; always accepted, no backpressure.
- free_id  in  ID_W  ID being returned; pool = free_id[ID_W-1:$clog2(POOL_DEPTH)].
- alloc_valid  out  NUM_POOLS  pool p head ID available.
- alloc_id  out  NUM_POOLS*ID_W  head ID of pool p at slice p (show-ahead).
- alloc_ready  in  NUM_POOLS  consume pool p head when valid&ready.
- free_count  out  NUM_POOLS*($clog2(POOL_DEPTH)+1)  IDs currently in pool p.
- pool_low  out  NUM_POOLS  free_count[p] < LOW_WATER.
- init_done  out  1  initialisation complete.
- err_double_free  out  1  one-cycle pulse: freed ID already in list; free dropped.
- err_early_free  out  1  one-cycle pulse: free_valid while ~init_done; free dropped.
- err_id  out  ID_W  ID of the most recent error; held until the next error.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0: alloc_valid, free_count, init_done, err_*, err_id. pool_low = 1 for every pool, since count 0 < LOW_WATER.
  - Bitmap cleared. All pools emptied.
- FSM:
  - INIT: local index i = 0..POOL_DEPTH-1, one per cycle. Every pool p writes ID p*POOL_DEPTH+i simultaneously and sets that ID's bitmap bit.
  - INIT lasts exactly POOL_DEPTH cycles. init_done rises on the edge after the last write, then the FSM enters RUN. No other transitions.
- alloc_valid[p] = init_done & pool p non-empty. It never depends on alloc_ready.
- Allocate handshake on pool p (alloc_valid[p] & alloc_ready[p]):
  - Pops the head. Clears the bitmap bit of alloc_id[p]. Decrements free_count[p].
  - The next head appears on the following cycle, so back-to-back allocation is supported at 1 ID/cycle/pool.
- Free (free_valid & init_done):
  - If the bitmap bit is 0: set it, push to the owning pool, increment free_count.
  - If the bitmap bit is 1: drop the ID, pulse err_double_free, load err_id.
- Free latency:
  - Free sampled at edge k into an empty pool -> alloc_valid high and alloc_id valid after edge k+2, no earlier.
  - free_count updates after edge k+1.
- Simultaneous allocate and free on the same pool: both take effect; free_count is unchanged.
  - Freeing the ID being allocated in the same cycle is a double free: the bitmap read sees the pre-allocation value, so the free is dropped.
- Allocates on different pools are independent; all NUM_POOLS may fire in one cycle.
- Overflow is impossible without a double free. Each pool FIFO holds exactly POOL_DEPTH entries.
- Underflow: alloc_ready while ~alloc_valid is ignored; no state change.
- Error priority: err_early_free beats err_double_free. err_id takes the ID of the pulse being raised.
- pool_low is registered from the updated free_count. Same latency as free_count.
- Reset mid-operation:
  - All state is cleared immediately, including in-flight frees.
  - INIT reruns in full and every ID is restored. Outstanding IDs held by clients are invalid after reset.

Decomposition:
- Package freelist_pkg: id_w(num_pools, depth) and cnt_w(depth) functions; the fsm_t enum (INIT, RUN); pool_select helper extracting the pool index from an ID.
- Sub-module freelist_pool, instantiated NUM_POOLS times. Contents:
  - LUTRAM FIFO of depth POOL_DEPTH with registered show-ahead head.
  - Occupancy counter.
  - pool_low logic.
- The top level holds the FSM, the bitmap (NUM_POOLS*POOL_DEPTH flops), free routing and error logic.

Test Plan:
- Init (defaults) -> init_done rises 256 cycles after rst release. Pool 2 then allocates 512, 513, 514 on consecutive cycles. free_count[2] = 253.
- Drain pool 0 (256 allocates) -> alloc_valid[0] = 0, free_count[0] = 0, pool_low[0] = 1. Free 17 at edge k -> alloc_valid[0] = 1 with id 17 after edge k+2.
- Allocate 5, free 5, free 5 again -> second free dropped. err_double_free pulses one cycle, err_id = 5, free_count[0] = 256. Free of the never-allocated ID 300 -> also err_double_free.
- Pool 1 at count 100: allocate head and free ID 260 in the same cycle -> free_count[1] stays 100. Freeing the ID allocated in that same cycle -> err_double_free.
- free_valid with id 3 during INIT -> err_early_free pulse, err_id = 3, and pool contents after init exactly 0..255.
- rst asserted mid-run after 100 allocates from pool 3 -> alloc_valid and init_done drop asynchronously. Re-init completes; pool 3 yields 768..1023 and free_count[3] = 256.
